// File: rtl/ysyx_22050710_csr_regfile.sv
// Machine-mode CSR register file for the RV64 core.
// Holds trap/return state and the counters, and produces the PC redirect target.
module ysyx_22050710_csr_regfile #(
    parameter int WORD_WD     = 64,
    parameter int PC_WD       = 64,
    parameter int CSR_WD      = 64,
    parameter int CSR_ADDR_WD = 12
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [CSR_ADDR_WD-1:0] i_csr_raddr,
    output logic [CSR_WD-1:0]      o_csrrdata,
    output logic                   o_csr_illegal,
    input  logic                   i_csr_wen,
    input  logic [CSR_ADDR_WD-1:0] i_csr_waddr,
    input  logic [CSR_WD-1:0]      i_csr_wdata,
    input  logic [PC_WD-1:0]       i_pc,
    input  logic                   i_ecall_sel,
    input  logic                   i_mret_sel,
    input  logic                   i_irq_take,
    input  logic                   i_retire,
    input  logic                   i_mtip,
    output logic                   o_irq_pending,
    output logic                   o_redirect_sel,
    output logic [PC_WD-1:0]       o_redirect_pc
);

    localparam logic [CSR_ADDR_WD-1:0] ADDR_MSTATUS  = CSR_ADDR_WD'(12'h300);
    localparam logic [CSR_ADDR_WD-1:0] ADDR_MIE      = CSR_ADDR_WD'(12'h304);
    localparam logic [CSR_ADDR_WD-1:0] ADDR_MTVEC    = CSR_ADDR_WD'(12'h305);
    localparam logic [CSR_ADDR_WD-1:0] ADDR_MSCRATCH = CSR_ADDR_WD'(12'h340);
    localparam logic [CSR_ADDR_WD-1:0] ADDR_MEPC     = CSR_ADDR_WD'(12'h341);
    localparam logic [CSR_ADDR_WD-1:0] ADDR_MCAUSE   = CSR_ADDR_WD'(12'h342);
    localparam logic [CSR_ADDR_WD-1:0] ADDR_MIP      = CSR_ADDR_WD'(12'h344);
    localparam logic [CSR_ADDR_WD-1:0] ADDR_MCYCLE   = CSR_ADDR_WD'(12'hB00);
    localparam logic [CSR_ADDR_WD-1:0] ADDR_MINSTRET = CSR_ADDR_WD'(12'hB02);
    localparam logic [CSR_ADDR_WD-1:0] ADDR_CYCLE    = CSR_ADDR_WD'(12'hC00);
    localparam logic [CSR_ADDR_WD-1:0] ADDR_INSTRET  = CSR_ADDR_WD'(12'hC02);

    localparam logic [CSR_WD-1:0] CAUSE_ECALL = CSR_WD'(11);
    localparam logic [CSR_WD-1:0] CAUSE_MTI   = {1'b1, {(CSR_WD-4){1'b0}}, 3'd7};

    logic                 mstatus_mie;
    logic                 mstatus_mpie;
    logic                 mie_mtie;
    logic                 mip_mtip;
    logic [CSR_WD-1:0]    mtvec;
    logic [CSR_WD-1:0]    mscratch;
    logic [CSR_WD-1:0]    mepc;
    logic [CSR_WD-1:0]    mcause;
    logic [WORD_WD-1:0]   mcycle;
    logic [WORD_WD-1:0]   minstret;

    logic trap_fire;
    logic mret_fire;
    logic wr_protected;
    logic wen_eff;
    logic we_mstatus, we_mie, we_mtvec, we_mscratch, we_mepc, we_mcause;
    logic we_mcycle, we_minstret;

    // mstatus image: MPP is hardwired to machine mode.
    function automatic logic [CSR_WD-1:0] mstatus_word(input logic mpie, input logic mie);
        logic [CSR_WD-1:0] w;
        w       = '0;
        w[12:11] = 2'b11;
        w[7]    = mpie;
        w[3]    = mie;
        return w;
    endfunction

    function automatic logic [CSR_WD-1:0] align4(input logic [CSR_WD-1:0] v);
        return {v[CSR_WD-1:2], 2'b00};
    endfunction

    // Event priority: irq_take > ecall > mret > CSR write.
    assign trap_fire = ~i_rst & (i_irq_take | i_ecall_sel);
    assign mret_fire = ~i_rst & i_mret_sel & ~(i_irq_take | i_ecall_sel);

    assign wr_protected = (i_csr_waddr == ADDR_MSTATUS) || (i_csr_waddr == ADDR_MEPC)
                       || (i_csr_waddr == ADDR_MCAUSE);
    assign wen_eff      = i_csr_wen & ~((trap_fire | mret_fire) & wr_protected);

    assign we_mstatus  = wen_eff && (i_csr_waddr == ADDR_MSTATUS);
    assign we_mie      = wen_eff && (i_csr_waddr == ADDR_MIE);
    assign we_mtvec    = wen_eff && (i_csr_waddr == ADDR_MTVEC);
    assign we_mscratch = wen_eff && (i_csr_waddr == ADDR_MSCRATCH);
    assign we_mepc     = wen_eff && (i_csr_waddr == ADDR_MEPC);
    assign we_mcause   = wen_eff && (i_csr_waddr == ADDR_MCAUSE);
    assign we_mcycle   = wen_eff && (i_csr_waddr == ADDR_MCYCLE);
    assign we_minstret = wen_eff && (i_csr_waddr == ADDR_MINSTRET);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
        end else if (trap_fire) begin
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
        end else if (mret_fire) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
        end else if (we_mstatus) begin
            mstatus_mie  <= i_csr_wdata[3];
            mstatus_mpie <= i_csr_wdata[7];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mie_mtie <= 1'b0;
            mip_mtip <= 1'b0;
            mtvec    <= '0;
            mscratch <= '0;
        end else begin
            mip_mtip <= i_mtip;
            if (we_mie)      mie_mtie <= i_csr_wdata[7];
            if (we_mtvec)    mtvec    <= align4(i_csr_wdata);
            if (we_mscratch) mscratch <= i_csr_wdata;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mepc   <= '0;
            mcause <= '0;
        end else if (trap_fire) begin
            mepc   <= align4(CSR_WD'(i_pc));
            mcause <= i_irq_take ? CAUSE_MTI : CAUSE_ECALL;
        end else begin
            if (we_mepc)   mepc   <= align4(i_csr_wdata);
            if (we_mcause) mcause <= i_csr_wdata;
        end
    end

    // A same-cycle write lands exactly and replaces that cycle's increment.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            if (we_mcycle) mcycle <= WORD_WD'(i_csr_wdata);
            else           mcycle <= mcycle + WORD_WD'(1);
            if (we_minstret)   minstret <= WORD_WD'(i_csr_wdata);
            else if (i_retire) minstret <= minstret + WORD_WD'(1);
        end
    end

    always_comb begin
        o_csrrdata    = '0;
        o_csr_illegal = 1'b0;
        case (i_csr_raddr)
            ADDR_MSTATUS:  o_csrrdata = mstatus_word(mstatus_mpie, mstatus_mie);
            ADDR_MIE:      o_csrrdata = CSR_WD'({mie_mtie, 7'b0});
            ADDR_MTVEC:    o_csrrdata = mtvec;
            ADDR_MSCRATCH: o_csrrdata = mscratch;
            ADDR_MEPC:     o_csrrdata = mepc;
            ADDR_MCAUSE:   o_csrrdata = mcause;
            ADDR_MIP:      o_csrrdata = CSR_WD'({mip_mtip, 7'b0});
            ADDR_MCYCLE,
            ADDR_CYCLE:    o_csrrdata = CSR_WD'(mcycle);
            ADDR_MINSTRET,
            ADDR_INSTRET:  o_csrrdata = CSR_WD'(minstret);
            default:       o_csr_illegal = 1'b1;
        endcase
    end

    assign o_irq_pending  = mstatus_mie & mie_mtie & mip_mtip;
    assign o_redirect_sel = trap_fire | mret_fire;

    always_comb begin
        o_redirect_pc = '0;
        if (trap_fire)      o_redirect_pc = PC_WD'(mtvec);
        else if (mret_fire) o_redirect_pc = PC_WD'(mepc);
    end

endmodule

// File: tb/tb_ysyx_22050710_csr_regfile.sv
// Bench for the CSR register file: directed scenarios plus randomized traffic
// compared against a CSR-level reference model.
module tb_ysyx_22050710_csr_regfile;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [11:0] i_csr_raddr = '0;
    logic [63:0] o_csrrdata;
    logic        o_csr_illegal;
    logic        i_csr_wen = 1'b0;
    logic [11:0] i_csr_waddr = '0;
    logic [63:0] i_csr_wdata = '0;
    logic [63:0] i_pc = '0;
    logic        i_ecall_sel = 1'b0;
    logic        i_mret_sel = 1'b0;
    logic        i_irq_take = 1'b0;
    logic        i_retire = 1'b0;
    logic        i_mtip = 1'b0;
    logic        o_irq_pending;
    logic        o_redirect_sel;
    logic [63:0] o_redirect_pc;

    int checks = 0;
    int errors = 0;

    ysyx_22050710_csr_regfile #(
        .WORD_WD(64), .PC_WD(64), .CSR_WD(64), .CSR_ADDR_WD(12)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_csr_raddr(i_csr_raddr), .o_csrrdata(o_csrrdata), .o_csr_illegal(o_csr_illegal),
        .i_csr_wen(i_csr_wen), .i_csr_waddr(i_csr_waddr), .i_csr_wdata(i_csr_wdata),
        .i_pc(i_pc), .i_ecall_sel(i_ecall_sel), .i_mret_sel(i_mret_sel),
        .i_irq_take(i_irq_take), .i_retire(i_retire), .i_mtip(i_mtip),
        .o_irq_pending(o_irq_pending), .o_redirect_sel(o_redirect_sel),
        .o_redirect_pc(o_redirect_pc)
    );

    always #5 i_clk = ~i_clk;

    // Reference model: architectural CSR values as full 64-bit words.
    logic [63:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mip;
    logic [63:0] m_mcycle, m_minstret;

    logic [11:0] csr_list [11] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                   12'h344, 12'hB00, 12'hB02, 12'hC00, 12'hC02};

    task automatic model_reset();
        m_mstatus = 64'h1800; m_mie = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0;
        m_mcause = 0; m_mip = 0; m_mcycle = 0; m_minstret = 0;
    endtask

    function automatic logic [63:0] model_rdata(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return m_mip;
            12'hB00, 12'hC00: return m_mcycle;
            12'hB02, 12'hC02: return m_minstret;
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic model_illegal(input logic [11:0] a);
        foreach (csr_list[k]) if (csr_list[k] == a) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic model_trap();
        return i_irq_take || i_ecall_sel;
    endfunction

    function automatic logic model_ret();
        return i_mret_sel && !model_trap();
    endfunction

    function automatic logic [63:0] model_redirect_pc();
        if (model_trap()) return m_mtvec;
        if (model_ret())  return m_mepc;
        return 64'd0;
    endfunction

    function automatic logic model_pending();
        return m_mstatus[3] && m_mie[7] && m_mip[7];
    endfunction

    // Applies one clock edge's worth of architectural effects.
    task automatic model_step();
        logic        trap, ret, blocked;
        logic [63:0] ns, nie, ntvec, nscr, nepc, ncause, ncyc, nret;
        if (i_rst) begin model_reset(); return; end
        trap = model_trap();
        ret  = model_ret();
        ns = m_mstatus; nie = m_mie; ntvec = m_mtvec; nscr = m_mscratch;
        nepc = m_mepc; ncause = m_mcause;
        ncyc = m_mcycle + 1;
        nret = m_minstret + (i_retire ? 64'd1 : 64'd0);
        blocked = (trap || ret) && (i_csr_waddr == 12'h300 || i_csr_waddr == 12'h341
                                    || i_csr_waddr == 12'h342);
        if (i_csr_wen && !blocked) begin
            case (i_csr_waddr)
                12'h300: ns     = (i_csr_wdata & 64'h88) | 64'h1800;
                12'h304: nie    = i_csr_wdata & 64'h80;
                12'h305: ntvec  = i_csr_wdata & ~64'd3;
                12'h340: nscr   = i_csr_wdata;
                12'h341: nepc   = i_csr_wdata & ~64'd3;
                12'h342: ncause = i_csr_wdata;
                12'hB00: ncyc   = i_csr_wdata;
                12'hB02: nret   = i_csr_wdata;
                default: ;
            endcase
        end
        if (trap) begin
            nepc   = i_pc & ~64'd3;
            ncause = i_irq_take ? 64'h8000_0000_0000_0007 : 64'd11;
            ns     = 64'h1800 | (m_mstatus[3] ? 64'h80 : 64'h0);
        end else if (ret) begin
            ns     = 64'h1880 | (m_mstatus[7] ? 64'h8 : 64'h0);
        end
        m_mstatus = ns; m_mie = nie; m_mtvec = ntvec; m_mscratch = nscr; m_mepc = nepc;
        m_mcause = ncause; m_mcycle = ncyc; m_minstret = nret;
        m_mip = i_mtip ? 64'h80 : 64'h0;
    endtask

    task automatic tick();
        @(posedge i_clk);
        model_step();
        @(negedge i_clk);
    endtask

    task automatic idle();
        i_csr_wen = 0; i_ecall_sel = 0; i_mret_sel = 0; i_irq_take = 0; i_retire = 0;
    endtask

    task automatic write_csr(input logic [11:0] a, input logic [63:0] d);
        i_csr_wen = 1; i_csr_waddr = a; i_csr_wdata = d;
        tick();
        i_csr_wen = 0;
    endtask

    task automatic test_reset();
        idle();
        i_rst = 1;
        model_reset();
        tick(); tick();
        i_rst = 0;
        i_csr_raddr = 12'h300; #1;
        checks++;
        if (o_csrrdata !== 64'h1800) begin
            errors++; $display("FAIL reset_mstatus got=%h exp=%h", o_csrrdata, 64'h1800);
        end
        i_csr_raddr = 12'h305; #1;
        checks++;
        if (o_csrrdata !== 64'h0) begin
            errors++; $display("FAIL reset_mtvec got=%h exp=0", o_csrrdata);
        end
        checks++;
        if (o_irq_pending !== 1'b0 || o_redirect_sel !== 1'b0) begin
            errors++; $display("FAIL reset_outputs pend=%b redir=%b exp=0/0", o_irq_pending, o_redirect_sel);
        end
    endtask

    task automatic test_mtvec_write();
        write_csr(12'h305, 64'h8000_0103);
        i_csr_raddr = 12'h305; #1;
        checks++;
        if (o_csrrdata !== 64'h8000_0100) begin
            errors++; $display("FAIL mtvec_align got=%h exp=%h", o_csrrdata, 64'h8000_0100);
        end
        i_csr_raddr = 12'h7C0; #1;
        checks++;
        if (o_csrrdata !== 64'h0 || o_csr_illegal !== 1'b1) begin
            errors++; $display("FAIL illegal_addr data=%h ill=%b exp=0/1", o_csrrdata, o_csr_illegal);
        end
    endtask

    task automatic test_ecall_mret();
        write_csr(12'h300, 64'h8);
        i_pc = 64'h8000_0024; i_ecall_sel = 1; #1;
        checks++;
        if (o_redirect_sel !== 1'b1 || o_redirect_pc !== 64'h8000_0100) begin
            errors++; $display("FAIL ecall_redirect sel=%b pc=%h exp=1/%h", o_redirect_sel, o_redirect_pc, 64'h8000_0100);
        end
        tick();
        i_ecall_sel = 0;
        i_csr_raddr = 12'h341; #1;
        checks++;
        if (o_csrrdata !== 64'h8000_0024) begin
            errors++; $display("FAIL ecall_mepc got=%h exp=%h", o_csrrdata, 64'h8000_0024);
        end
        i_csr_raddr = 12'h342; #1;
        checks++;
        if (o_csrrdata !== 64'd11) begin
            errors++; $display("FAIL ecall_mcause got=%h exp=%h", o_csrrdata, 64'd11);
        end
        i_csr_raddr = 12'h300; #1;
        checks++;
        if (o_csrrdata !== 64'h1880) begin
            errors++; $display("FAIL ecall_mstatus got=%h exp=%h", o_csrrdata, 64'h1880);
        end
        i_mret_sel = 1; #1;
        checks++;
        if (o_redirect_sel !== 1'b1 || o_redirect_pc !== 64'h8000_0024) begin
            errors++; $display("FAIL mret_redirect sel=%b pc=%h exp=1/%h", o_redirect_sel, o_redirect_pc, 64'h8000_0024);
        end
        tick();
        i_mret_sel = 0; #1;
        checks++;
        if (o_csrrdata !== 64'h1888) begin
            errors++; $display("FAIL mret_mstatus got=%h exp=%h", o_csrrdata, 64'h1888);
        end
    endtask

    task automatic test_irq();
        write_csr(12'h304, 64'h80);
        i_mtip = 1; #1;
        checks++;
        if (o_irq_pending !== 1'b0) begin
            errors++; $display("FAIL irq_pending_early got=%b exp=0", o_irq_pending);
        end
        tick(); #1;
        checks++;
        if (o_irq_pending !== 1'b1) begin
            errors++; $display("FAIL irq_pending got=%b exp=1", o_irq_pending);
        end
        i_irq_take = 1; i_csr_wen = 1; i_csr_waddr = 12'h340; i_csr_wdata = 64'd5; #1;
        checks++;
        if (o_redirect_sel !== 1'b1 || o_redirect_pc !== 64'h8000_0100) begin
            errors++; $display("FAIL irq_redirect sel=%b pc=%h exp=1/%h", o_redirect_sel, o_redirect_pc, 64'h8000_0100);
        end
        tick();
        idle();
        i_csr_raddr = 12'h342; #1;
        checks++;
        if (o_csrrdata !== 64'h8000_0000_0000_0007) begin
            errors++; $display("FAIL irq_mcause got=%h exp=%h", o_csrrdata, 64'h8000_0000_0000_0007);
        end
        i_csr_raddr = 12'h340; #1;
        checks++;
        if (o_csrrdata !== 64'd5) begin
            errors++; $display("FAIL irq_mscratch got=%h exp=5", o_csrrdata);
        end
        i_csr_raddr = 12'h300; #1;
        checks++;
        if (o_csrrdata[3] !== 1'b0 || o_irq_pending !== 1'b0) begin
            errors++; $display("FAIL irq_mie_clear mstatus=%h pend=%b exp MIE=0 pend=0", o_csrrdata, o_irq_pending);
        end
        i_mtip = 0;
        tick();
    endtask

    task automatic test_counters();
        write_csr(12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
        i_csr_raddr = 12'hB00; #1;
        checks++;
        if (o_csrrdata !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++; $display("FAIL mcycle_write got=%h exp=all-ones", o_csrrdata);
        end
        tick(); #1;
        checks++;
        if (o_csrrdata !== 64'h0) begin
            errors++; $display("FAIL mcycle_wrap got=%h exp=0", o_csrrdata);
        end
        write_csr(12'hB02, 64'd0);
        i_retire = 1;
        repeat (3) tick();
        i_retire = 0;
        i_csr_raddr = 12'hB02; #1;
        checks++;
        if (o_csrrdata !== 64'd3) begin
            errors++; $display("FAIL minstret got=%0d exp=3", o_csrrdata);
        end
        i_csr_raddr = 12'hC02; #1;
        checks++;
        if (o_csrrdata !== 64'd3) begin
            errors++; $display("FAIL instret_alias got=%0d exp=3", o_csrrdata);
        end
    endtask

    task automatic test_priority();
        // ecall + mret + mstatus write together: only the ecall takes effect.
        write_csr(12'h300, 64'h8);
        i_pc = 64'h8000_0203; i_ecall_sel = 1; i_mret_sel = 1;
        i_csr_wen = 1; i_csr_waddr = 12'h300; i_csr_wdata = 64'h88; #1;
        checks++;
        if (o_redirect_pc !== model_redirect_pc()) begin
            errors++; $display("FAIL prio_redirect got=%h exp=%h", o_redirect_pc, model_redirect_pc());
        end
        tick();
        idle();
        i_csr_raddr = 12'h300; #1;
        checks++;
        if (o_csrrdata !== model_rdata(12'h300) || o_csrrdata !== 64'h1880) begin
            errors++; $display("FAIL prio_mstatus got=%h exp=%h", o_csrrdata, 64'h1880);
        end
        i_csr_raddr = 12'h341; #1;
        checks++;
        if (o_csrrdata !== 64'h8000_0200) begin
            errors++; $display("FAIL prio_mepc got=%h exp=%h", o_csrrdata, 64'h8000_0200);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            i_csr_raddr = ($urandom_range(0, 9) < 8) ? csr_list[$urandom_range(0, 10)]
                                                     : 12'($urandom);
            i_csr_wen   = ($urandom_range(0, 3) == 0);
            i_csr_waddr = ($urandom_range(0, 9) < 9) ? csr_list[$urandom_range(0, 10)]
                                                     : 12'($urandom);
            i_csr_wdata = {$urandom, $urandom};
            i_pc        = {$urandom, $urandom};
            i_ecall_sel = ($urandom_range(0, 9) == 0);
            i_mret_sel  = ($urandom_range(0, 9) == 0);
            i_irq_take  = ($urandom_range(0, 14) == 0);
            i_retire    = 1'($urandom);
            i_mtip      = ($urandom_range(0, 3) == 0);
            #1;
            checks++;
            if (o_csrrdata !== model_rdata(i_csr_raddr) || o_csr_illegal !== model_illegal(i_csr_raddr)) begin
                errors++; $display("FAIL rand_read[%0d] addr=%h got=%h/%b exp=%h/%b", n, i_csr_raddr,
                                   o_csrrdata, o_csr_illegal, model_rdata(i_csr_raddr), model_illegal(i_csr_raddr));
            end
            checks++;
            if (o_redirect_sel !== (model_trap() || model_ret()) || o_redirect_pc !== model_redirect_pc()) begin
                errors++; $display("FAIL rand_redirect[%0d] got=%b/%h exp=%b/%h", n, o_redirect_sel,
                                   o_redirect_pc, model_trap() || model_ret(), model_redirect_pc());
            end
            checks++;
            if (o_irq_pending !== model_pending()) begin
                errors++; $display("FAIL rand_pending[%0d] got=%b exp=%b", n, o_irq_pending, model_pending());
            end
            tick();
        end
        idle();
        i_mtip = 0;
    endtask

    task automatic test_reset_mid();
        write_csr(12'h340, 64'hDEAD_BEEF);
        write_csr(12'h305, 64'h1234_5678);
        #1;
        i_rst = 1;
        model_reset();
        for (int k = 0; k < 11; k++) begin
            i_csr_raddr = csr_list[k]; #1;
            checks++;
            if (o_csrrdata !== ((csr_list[k] == 12'h300) ? 64'h1800 : 64'h0)) begin
                errors++; $display("FAIL midreset[%h] got=%h exp=%h", csr_list[k], o_csrrdata,
                                   (csr_list[k] == 12'h300) ? 64'h1800 : 64'h0);
            end
        end
        @(negedge i_clk);
        i_rst = 0;
        tick();
        i_csr_raddr = 12'hB00; #1;
        checks++;
        if (o_csrrdata !== 64'd1) begin
            errors++; $display("FAIL post_reset_mcycle got=%0d exp=1", o_csrrdata);
        end
    endtask

    initial begin
        test_reset();
        test_mtvec_write();
        test_ecall_mret();
        test_irq();
        test_counters();
        test_priority();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_22050710_csr_regfile.md
Name: ysyx_22050710_csr_regfile

Overview:
- Machine-mode CSR register file for the single-issue RV64 core.
- Forms the other end of the execute unit's CSR path:
  - supplies the CSR read operand the execute unit consumes;
  - commits the computed CSR result the execute unit produces.
- Owns trap and return state (ecall, timer interrupt, mret) and the cycle/instret counters.
- Produces the PC redirect target for traps and returns.

Parameters:
- WORD_WD, 64, datapath width.
- PC_WD, 64, program counter width.
- CSR_WD, 64, CSR data width.
- CSR_ADDR_WD, 12, CSR address width.

Ports:
- i_clk  input  1  core clock; all state updates on the rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_csr_raddr  input  CSR_ADDR_WD  CSR read address (inst[31:20]).
- o_csrrdata  output  CSR_WD  combinational read data.
- o_csr_illegal  output  1  i_csr_raddr is not implemented.
- i_csr_wen  input  1  commit i_csr_wdata this cycle.
- i_csr_waddr  input  CSR_ADDR_WD  CSR write address.
- i_csr_wdata  input  CSR_WD  CSR result from the execute unit.
- i_pc  input  PC_WD  PC of the instruction in this stage.
- i_ecall_sel  input  1  current instruction is ecall.
- i_mret_sel  input  1  current instruction is mret.
- i_irq_take  input  1  core accepts the pending interrupt at this instruction boundary.
- i_retire  input  1  one instruction retires this cycle.
- i_mtip  input  1  machine timer interrupt level.
- o_irq_pending  output  1  mstatus.MIE & mie.MTIE & mip.MTIP.
- o_redirect_sel  output  1  redirect the PC this cycle.
- o_redirect_pc  output  PC_WD  redirect target.

Behaviour:
- Implemented CSRs:
  - mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mip 0x344.
  - mcycle 0xB00, minstret 0xB02.
  - Read-only aliases: cycle 0xC00, instret 0xC02.
- Reset values, applied asynchronously: all CSRs 0, except mstatus.MPP = 2'b11.
- Outputs from reset state:
  - o_irq_pending = 0;
  - o_redirect_sel = 0, given no event inputs.
- Read path:
  - o_csrrdata is combinational and reflects register state before the current edge; no bypass.
  - Unimplemented address: o_csrrdata = 0 and o_csr_illegal = 1.
- Write path (on i_csr_wen, at the edge, 1-cycle latency):
  - mstatus: only MIE[3], MPIE[7] writable; MPP stays 2'b11; other bits read 0.
  - mie: only MTIE[7] writable.
  - mtvec: bits [1:0] forced to 0 (direct mode only).
  - mepc: bits [1:0] forced to 0.
  - mip: writes ignored; MTIP[7] is sampled from i_mtip every cycle.
  - Writes to 0xC00/0xC02 or to unimplemented addresses are dropped.
- Counters:
  - mcycle increments by 1 every cycle out of reset.
  - minstret increments when i_retire = 1.
  - Both wrap from 2^64-1 to 0.
  - A CSR write to a counter in the same cycle overrides that cycle's increment (written value lands exactly).
- Trap (i_ecall_sel | i_irq_take), at the edge:
  - mepc <= i_pc & ~3.
  - mcause <= 11 for ecall; 0x8000_0000_0000_0007 for irq_take.
  - MPIE <= MIE; MIE <= 0.
- Return (i_mret_sel), at the edge: MIE <= MPIE; MPIE <= 1.
- Redirect (combinational, same cycle as the event):
  - Trap: o_redirect_sel = 1, o_redirect_pc = mtvec.
  - mret: o_redirect_sel = 1, o_redirect_pc = mepc.
  - Otherwise o_redirect_sel = 0 and o_redirect_pc = 0.
- Priority within one cycle: irq_take > ecall > mret > CSR write.
  - A lower-priority event is fully suppressed.
  - CSR write to mepc/mcause/mstatus is dropped when a trap or mret fires that cycle.
  - Writes to other CSRs still commit.
- Reset mid-operation: all state returns to reset values immediately; any pending event is discarded.

Test Plan:
- Reset, then read 0x300 -> 0x1800; read 0x305 -> 0; o_irq_pending = 0; o_redirect_sel = 0.
- Write mtvec 0x8000_0103, then read next cycle -> 0x8000_0100; read 0x7C0 -> data 0, o_csr_illegal = 1.
- mtvec = 0x8000_0100, MIE = 1, ecall at pc 0x8000_0024:
  - same cycle: o_redirect_pc = 0x8000_0100;
  - next cycle: mepc = 0x8000_0024, mcause = 11, mstatus = 0x1880.
- Following mret -> o_redirect_pc = 0x8000_0024; next cycle mstatus = 0x1888.
- MIE = 1, MTIE = 1, i_mtip = 1:
  - o_irq_pending = 1 one cycle after i_mtip rises;
  - i_irq_take with a simultaneous mscratch write of 5 -> mcause = 0x8000_0000_0000_0007, mscratch = 5, MIE = 0, o_irq_pending = 0.
- Write mcycle = 0xFFFF_FFFF_FFFF_FFFF -> next cycle reads that value, following cycle reads 0.
- 3 cycles with i_retire = 1 -> minstret = 3.
- Assert i_rst mid-run -> all CSRs 0 except mstatus = 0x1800.
